// File: rtl/data_dma_engine.sv
// Block copy / block fill DMA initiator on the data-memory port. Optional checksum output: DATA_DMA_CHECKSUM_EN.
// Latency: done 2 cycles after start for length 0; fill = 1 word/cycle, copy = 2+ReadLatency cycles/word under grant.
// Backpressure: memReq/memGrant handshake, grant sampled only at word boundaries; enable=0 freezes everything.
module data_dma_engine #(
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 32,
    parameter int LenWidth    = 16,
    parameter int ReadLatency = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 fill,
    input  logic [AddrWidth-1:0] srcAddr,
    input  logic [AddrWidth-1:0] dstAddr,
    input  logic [LenWidth-1:0]  length,
    input  logic [DataWidth-1:0] fillData,
    output logic                 busy,
    output logic                 done,
    output logic                 memReq,
    input  logic                 memGrant,
    output logic                 write,
    output logic [AddrWidth-1:0] addr,
    output logic [DataWidth-1:0] wData,
    output logic [DataWidth-1:0] wDataMask,
    input  logic [DataWidth-1:0] rData
`ifdef DATA_DMA_CHECKSUM_EN
    ,
    output logic [DataWidth-1:0] checksum
`endif
);

    typedef enum logic [2:0] {IDLE, REQ, RD, RWAIT, WR, FIN} state_t;

    localparam logic [AddrWidth-1:0] Step      = AddrWidth'(DataWidth / 8);
    localparam logic [AddrWidth-1:0] AlignMask = AddrWidth'(DataWidth / 8 - 1);
    // RWAIT spans ReadLatency cycles; the counter holds the cycles still to go after the first.
    localparam logic [1:0]           WaitInit  = (ReadLatency > 0) ? 2'(ReadLatency - 1) : 2'd0;

    state_t                 state_q, state_d;
    logic [AddrWidth-1:0]   src_q, src_d;
    logic [AddrWidth-1:0]   dst_q, dst_d;
    logic [LenWidth-1:0]    rem_q, rem_d;
    logic [1:0]             wait_q, wait_d;
    logic                   mode_q, mode_d;
    logic [DataWidth-1:0]   pat_q, pat_d;

    logic                   busy_d, done_d, req_d, write_d;
    logic [AddrWidth-1:0]   addr_d;
    logic [DataWidth-1:0]   wdata_d, mask_d;
    logic                   start_acc;

    // A start coinciding with the done pulse is dropped so the engine re-arms a cycle later.
    assign start_acc = (state_q == IDLE) && start && !done;

    // State and registered bus outputs; enable low freezes the whole engine.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            wait_q    <= '0;
            mode_q    <= 1'b0;
            pat_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            memReq    <= 1'b0;
            write     <= 1'b0;
            addr      <= '0;
            wData     <= '0;
            wDataMask <= '0;
        end else if (enable) begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            wait_q    <= wait_d;
            mode_q    <= mode_d;
            pat_q     <= pat_d;
            busy      <= busy_d;
            done      <= done_d;
            memReq    <= req_d;
            write     <= write_d;
            addr      <= addr_d;
            wData     <= wdata_d;
            wDataMask <= mask_d;
        end
    end

    // Next state, pointer updates, and the bus values for the state being entered.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        wait_d  = wait_q;
        mode_d  = mode_q;
        pat_d   = pat_q;
        busy_d  = busy;
        done_d  = 1'b0;
        write_d = 1'b0;
        addr_d  = addr;
        wdata_d = wData;
        mask_d  = wDataMask;

        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    src_d   = srcAddr & ~AlignMask;
                    dst_d   = dstAddr & ~AlignMask;
                    rem_d   = length;
                    mode_d  = fill;
                    pat_d   = fillData;
                    busy_d  = 1'b1;
                    state_d = (length == '0) ? FIN : REQ;
                end
            end
            REQ: begin
                if (memGrant) state_d = mode_q ? WR : RD;
            end
            RD: begin
                if (ReadLatency == 0) begin
                    state_d = WR;
                end else begin
                    state_d = RWAIT;
                    wait_d  = WaitInit;
                end
            end
            RWAIT: begin
                if (wait_q == 2'd0) state_d = WR;
                else                wait_d  = wait_q - 2'd1;
            end
            WR: begin
                src_d = src_q + Step;
                dst_d = dst_q + Step;
                rem_d = rem_q - LenWidth'(1);
                // Grant is only looked at here, at the word boundary.
                if (rem_q == LenWidth'(1)) state_d = FIN;
                else if (memGrant)         state_d = mode_q ? WR : RD;
                else                       state_d = REQ;
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Request is held from REQ through the last write, including re-requests after a grant loss.
        req_d = (state_d == REQ) || (state_d == RD) || (state_d == RWAIT) || (state_d == WR);
        if (state_d == RD) addr_d = src_d;
        if (state_d == WR) begin
            write_d = 1'b1;
            addr_d  = dst_d;
            mask_d  = '1;
            // In copy mode the read word arrives on rData exactly at the edge that enters WR.
            wdata_d = mode_q ? pat_q : rData;
        end
    end

`ifdef DATA_DMA_CHECKSUM_EN
    // Running sum of written words, restarted when a transfer is accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            checksum <= '0;
        end else if (enable) begin
            if (start_acc)            checksum <= '0;
            else if (state_q == WR)   checksum <= checksum + wData;
        end
    end
`endif

endmodule
